// File: rtl/pc_sequencer.sv
// Program-counter unit for the fetch stage.
// Covers sequential advance, redirects, stalls, a circular return-address stack and exception capture.
module pc_sequencer #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           STEP       = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = 32'h0000_0080,
    parameter int unsigned           RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  PCSrc,
    input  logic [ADDR_WIDTH-1:0] setAddress,
    input  logic                  call,
    input  logic                  ret,
    input  logic                  exception,
    output logic [ADDR_WIDTH-1:0] current_pc,
    output logic [ADDR_WIDTH-1:0] epc,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  ras_overflow,
    output logic                  ras_underflow
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] StepVal = ADDR_WIDTH'(STEP);
    localparam logic [CntW-1:0]       CntMax  = CntW'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, pc_inc;
    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PtrW-1:0]       tp_q, tp_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  push;

    assign pc_inc = pc_q + StepVal;

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        tp_d  = tp_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        push  = 1'b0;
        if (exception) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (call && ret) begin
            // Tail call: the callee returns straight to our caller, so the stack is untouched.
            pc_d = setAddress;
        end else if (ret) begin
            if (cnt_q != '0) begin
                pc_d  = ras_q[tp_q];
                tp_d  = tp_q - PtrW'(1);
                cnt_d = cnt_q - CntW'(1);
            end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end
        end else if (call) begin
            pc_d = setAddress;
            tp_d = tp_q + PtrW'(1);
            push = 1'b1;
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CntW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (PCSrc) begin
            pc_d = setAddress;
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_ADDR;
            epc_q <= '0;
            tp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack contents need no reset; when full, the new top slot is the oldest entry.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ras_q[tp_d] <= pc_inc;
        end
    end

    assign current_pc    = pc_q;
    assign epc           = epc_q;
    assign ras_empty     = (cnt_q == '0);
    assign ras_full      = (cnt_q == CntMax);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table on a default instance,
// plus a short wrap/stall sequence on a narrow instance.
module tb_pc_sequencer;

    typedef struct {
        logic        rst, stl, src, cal, rt, exc;
        logic [31:0] addr;
        logic [31:0] pc, epc;
        logic        empty, full, ovf, unf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, stall, pcsrc, call, ret, exception;
    logic [31:0] set_address, current_pc, epc;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow;

    logic       b_reset, b_stall, b_pcsrc, b_call, b_ret, b_exception;
    logic [7:0] b_set_address, b_current_pc, b_epc;
    logic       b_empty, b_full, b_ovf, b_unf;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .PCSrc(pcsrc), .setAddress(set_address),
        .call(call), .ret(ret), .exception(exception), .current_pc(current_pc), .epc(epc),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    pc_sequencer #(
        .ADDR_WIDTH(8), .STEP(4), .RESET_ADDR(8'h00), .EXC_VECTOR(8'h80), .RAS_DEPTH(4)
    ) dut_w (
        .clk(clk), .reset(b_reset), .stall(b_stall), .PCSrc(b_pcsrc), .setAddress(b_set_address),
        .call(b_call), .ret(b_ret), .exception(b_exception), .current_pc(b_current_pc),
        .epc(b_epc), .ras_empty(b_empty), .ras_full(b_full), .ras_overflow(b_ovf),
        .ras_underflow(b_unf)
    );

    function automatic vec_t mk(input logic rst, stl, src, cal, rt, exc, input logic [31:0] addr,
                                input logic [31:0] pc, e, input logic em, fu, ov, un);
        vec_t v;
        v.rst = rst; v.stl = stl; v.src = src; v.cal = cal; v.rt = rt; v.exc = exc;
        v.addr = addr; v.pc = pc; v.epc = e; v.empty = em; v.full = fu; v.ovf = ov; v.unf = un;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp_v);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        reset = v.rst; stall = v.stl; pcsrc = v.src; call = v.cal; ret = v.rt;
        exception = v.exc; set_address = v.addr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("current_pc", idx, current_pc, e.pc);
        check("epc", idx, epc, e.epc);
        check("ras_empty", idx, 32'(ras_empty), 32'(e.empty));
        check("ras_full", idx, 32'(ras_full), 32'(e.full));
        check("ras_overflow", idx, 32'(ras_overflow), 32'(e.ovf));
        check("ras_underflow", idx, 32'(ras_underflow), 32'(e.unf));
    endtask

    task automatic step_w(input logic rst, stl, src, input logic [7:0] addr,
                          input logic [7:0] exp_pc, input int idx);
        @(negedge clk);
        b_reset = rst; b_stall = stl; b_pcsrc = src; b_set_address = addr;
        @(posedge clk);
        #1;
        check("wrap_pc", idx, 32'(b_current_pc), 32'(exp_pc));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pcsrc = 1'b0; call = 1'b0; ret = 1'b0;
        exception = 1'b0; set_address = '0;
        b_reset = 1'b1; b_stall = 1'b0; b_pcsrc = 1'b0; b_call = 1'b0; b_ret = 1'b0;
        b_exception = 1'b0; b_set_address = '0;

        //                 rst stl src cal rt exc addr    pc      epc    em fu ov un
        // Reset, free-run
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 'h0,  'h0,  'h0,  1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 'h0,  'h0,  'h0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h0,  'h1,  'h0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h0,  'h2,  'h0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h0,  'h3,  'h0,  1, 0, 0, 0));
        // Nesting
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 'h10, 'h10, 'h0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h40, 'h40, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h0,  'h41, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h80, 'h80, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h0,  'h42, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h0,  'h11, 'h0,  1, 0, 0, 0));
        // Overflow / underflow
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 'h0,  'h0,  'h0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h10, 'h10, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h20, 'h20, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h30, 'h30, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h40, 'h40, 'h0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h50, 'h50, 'h0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h0,  'h51, 'h0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h0,  'h41, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h0,  'h31, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h0,  'h21, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h0,  'h11, 'h0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h0,  'h12, 'h0,  1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h0,  'h13, 'h0,  1, 0, 0, 0));
        // Exception under stall
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 'h25, 'h25, 'h0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 'h0,  'h80, 'h25, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 'h0,  'h80, 'h25, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h0,  'h81, 'h25, 1, 0, 0, 0));
        // Simultaneous events
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 'h5,  'h5,  'h25, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 'h60, 'h60, 'h25, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 'h70, 'h70, 'h25, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 'h90, 'h90, 'h25, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h0,  'h61, 'h25, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h20, 'h20, 'h25, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 'h0,  'h0,  'h0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h0,  'h1,  'h0,  1, 0, 0, 0));
        // Stalled ret holds stack and PC
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h30, 'h30, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 'h0,  'h30, 'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 'h0,  'h2,  'h0,  1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Narrow instance: wrap at 8 bits with STEP=4, then a 3-cycle stall.
        step_w(1, 0, 0, 8'h00, 8'h00, 0);
        step_w(0, 0, 1, 8'hFC, 8'hFC, 1);
        step_w(0, 0, 0, 8'h00, 8'h00, 2);
        step_w(0, 1, 0, 8'h00, 8'h00, 3);
        step_w(0, 1, 0, 8'h00, 8'h00, 4);
        step_w(0, 1, 0, 8'h00, 8'h00, 5);
        step_w(0, 0, 0, 8'h00, 8'h04, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
